// File: rtl/wb_tag_pipe_if.sv
// Bus between the ID stage and the destination-tag pipe: ID-side tag inputs and
// the per-stage tags, scoreboard and retire count published back to the core.
interface wb_tag_pipe_if #(
    parameter int RSIZE = 5,
    parameter int CNTW  = 32
);
    logic                  ID_Valid;
    logic [RSIZE-1:0]      ID_WAddr;
    logic                  ID_RFWen;
    logic                  ID_WDataSc2;
    logic                  stall;
    logic                  flush;

    logic                  EX_Valid;
    logic                  MEM_Valid;
    logic                  WB_Valid;
    logic [RSIZE-1:0]      EX_WAddr;
    logic [RSIZE-1:0]      MEM_WAddr;
    logic [RSIZE-1:0]      WB_WAddr;
    logic                  EX_RFWen;
    logic                  MEM_RFWen;
    logic                  WB_RFWen;
    logic                  EX_WDataSc2;
    logic                  MEM_WDataSc2;
    logic [2**RSIZE-1:0]   busy;
    logic [CNTW-1:0]       retire_cnt;

    modport master (
        output ID_Valid, ID_WAddr, ID_RFWen, ID_WDataSc2, stall, flush,
        input  EX_Valid, MEM_Valid, WB_Valid, EX_WAddr, MEM_WAddr, WB_WAddr,
               EX_RFWen, MEM_RFWen, WB_RFWen, EX_WDataSc2, MEM_WDataSc2,
               busy, retire_cnt
    );

    modport slave (
        input  ID_Valid, ID_WAddr, ID_RFWen, ID_WDataSc2, stall, flush,
        output EX_Valid, MEM_Valid, WB_Valid, EX_WAddr, MEM_WAddr, WB_WAddr,
               EX_RFWen, MEM_RFWen, WB_RFWen, EX_WDataSc2, MEM_WDataSc2,
               busy, retire_cnt
    );
endinterface

// File: rtl/wb_tag_pipe.sv
// Carries each instruction's destination tag from ID through EX, MEM and WB and
// derives the pending-write scoreboard and the retired-instruction counter.
module wb_tag_pipe #(
    parameter int RSIZE = 5,
    parameter int CNTW  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_tag_pipe_if.slave bus
);
    localparam int NREG = 2 ** RSIZE;

    logic              id_wen;
    logic              id_issue;
    logic              id_valid_next;
    logic              id_rfwen_next;
    logic [RSIZE-1:0]  id_waddr_next;
    logic              id_sc2_next;

    logic              ex_valid_reg,  mem_valid_reg,  wb_valid_reg;
    logic              ex_rfwen_reg,  mem_rfwen_reg,  wb_rfwen_reg;
    logic [RSIZE-1:0]  ex_waddr_reg,  mem_waddr_reg,  wb_waddr_reg;
    logic              ex_sc2_reg,    mem_sc2_reg;
    logic [CNTW-1:0]   retire_cnt_reg;

    // Writes to r0 are dropped here so nothing downstream has to special-case it.
    always_comb begin
        id_wen        = bus.ID_Valid & bus.ID_RFWen & (bus.ID_WAddr != '0);
        id_issue      = bus.ID_Valid & ~bus.stall & ~bus.flush;
        id_valid_next = id_issue;
        id_rfwen_next = id_issue & id_wen;
        id_waddr_next = (id_issue & id_wen) ? bus.ID_WAddr : '0;
        id_sc2_next   = id_issue & id_wen & bus.ID_WDataSc2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg   <= 1'b0;
            ex_rfwen_reg   <= 1'b0;
            ex_waddr_reg   <= '0;
            ex_sc2_reg     <= 1'b0;
            mem_valid_reg  <= 1'b0;
            mem_rfwen_reg  <= 1'b0;
            mem_waddr_reg  <= '0;
            mem_sc2_reg    <= 1'b0;
            wb_valid_reg   <= 1'b0;
            wb_rfwen_reg   <= 1'b0;
            wb_waddr_reg   <= '0;
            retire_cnt_reg <= '0;
        end else begin
            ex_valid_reg   <= id_valid_next;
            ex_rfwen_reg   <= id_rfwen_next;
            ex_waddr_reg   <= id_waddr_next;
            ex_sc2_reg     <= id_sc2_next;
            // The back end never stalls; already-issued instructions always drain.
            mem_valid_reg  <= ex_valid_reg;
            mem_rfwen_reg  <= ex_rfwen_reg;
            mem_waddr_reg  <= ex_waddr_reg;
            mem_sc2_reg    <= ex_sc2_reg;
            wb_valid_reg   <= mem_valid_reg;
            wb_rfwen_reg   <= mem_rfwen_reg;
            wb_waddr_reg   <= mem_waddr_reg;
            if (wb_valid_reg)
                retire_cnt_reg <= retire_cnt_reg + CNTW'(1);
        end
    end

    assign bus.EX_Valid     = ex_valid_reg;
    assign bus.EX_RFWen     = ex_rfwen_reg;
    assign bus.EX_WAddr     = ex_waddr_reg;
    assign bus.EX_WDataSc2  = ex_sc2_reg;
    assign bus.MEM_Valid    = mem_valid_reg;
    assign bus.MEM_RFWen    = mem_rfwen_reg;
    assign bus.MEM_WAddr    = mem_waddr_reg;
    assign bus.MEM_WDataSc2 = mem_sc2_reg;
    assign bus.WB_Valid     = wb_valid_reg;
    assign bus.WB_RFWen     = wb_rfwen_reg;
    assign bus.WB_WAddr     = wb_waddr_reg;
    assign bus.retire_cnt   = retire_cnt_reg;

    // r0 is hard-wired, so its scoreboard bit is a constant zero.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_r0
                assign bus.busy[gi] = 1'b0;
            end else begin : g_rn
                assign bus.busy[gi] =
                    (ex_valid_reg  & ex_rfwen_reg  & (ex_waddr_reg  == RSIZE'(gi))) |
                    (mem_valid_reg & mem_rfwen_reg & (mem_waddr_reg == RSIZE'(gi))) |
                    (wb_valid_reg  & wb_rfwen_reg  & (wb_waddr_reg  == RSIZE'(gi)));
            end
        end
    endgenerate
endmodule

// File: tb/tb_wb_tag_pipe.sv
// Scoreboard bench for wb_tag_pipe: stimulus queues the expected EX tag of every
// cycle, a monitor tracks the in-flight instructions and checks all outputs.
module tb_wb_tag_pipe;
    localparam int RSIZE = 5;
    localparam int CNTW  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_tag_pipe_if #(.RSIZE(RSIZE), .CNTW(CNTW)) bus ();

    wb_tag_pipe #(.RSIZE(RSIZE), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit v;
        bit rf;
        int wa;
        bit sc;
    } etag_t;

    etag_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One instruction slot presented to ID for one cycle.
    task automatic step(bit v, int wa, bit rf, bit sc, bit st, bit fl);
        etag_t t;
        bus.ID_Valid    = v;
        bus.ID_WAddr    = RSIZE'(wa);
        bus.ID_RFWen    = rf;
        bus.ID_WDataSc2 = sc;
        bus.stall       = st;
        bus.flush       = fl;
        t = '{0, 0, 0, 0};
        if (v && !st && !fl) begin
            t.v  = 1;
            t.rf = rf && (wa != 0);
            if (t.rf) begin
                t.wa = wa;
                t.sc = sc;
            end
        end
        exp_q.push_back(t);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_ex_valid"},  bus.EX_Valid,  0);
        chk({tag, "_mem_valid"}, bus.MEM_Valid, 0);
        chk({tag, "_wb_valid"},  bus.WB_Valid,  0);
        chk({tag, "_mem_waddr"}, bus.MEM_WAddr, 0);
        chk({tag, "_mem_sc2"},   bus.MEM_WDataSc2, 0);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_retire"},    bus.retire_cnt, 0);
    endtask

    // Monitor: model of the three in-flight slots and the retire count.
    etag_t hist[3];
    int    mcnt;

    initial begin
        etag_t     nx;
        logic [31:0] eb;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int s = 0; s < 3; s++) hist[s] = '{0, 0, 0, 0};
                mcnt = 0;
                continue;
            end
            nx = (exp_q.size() != 0) ? exp_q.pop_front() : '{0, 0, 0, 0};
            if (hist[2].v) begin
                mcnt = (mcnt + 1) % (2 ** CNTW);
                $display("retire: waddr=%0d rfwen=%0d count=%0d", hist[2].wa, hist[2].rf, mcnt);
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = nx;
            #1;
            eb = '0;
            for (int r = 1; r < 32; r++)
                for (int s = 0; s < 3; s++)
                    if (hist[s].v && hist[s].rf && hist[s].wa == r) eb[r] = 1'b1;
            chk("ex_valid",  bus.EX_Valid,     hist[0].v);
            chk("ex_rfwen",  bus.EX_RFWen,     hist[0].rf);
            chk("ex_waddr",  bus.EX_WAddr,     hist[0].wa);
            chk("ex_sc2",    bus.EX_WDataSc2,  hist[0].sc);
            chk("mem_valid", bus.MEM_Valid,    hist[1].v);
            chk("mem_rfwen", bus.MEM_RFWen,    hist[1].rf);
            chk("mem_waddr", bus.MEM_WAddr,    hist[1].wa);
            chk("mem_sc2",   bus.MEM_WDataSc2, hist[1].sc);
            chk("wb_valid",  bus.WB_Valid,     hist[2].v);
            chk("wb_rfwen",  bus.WB_RFWen,     hist[2].rf);
            chk("wb_waddr",  bus.WB_WAddr,     hist[2].wa);
            chk("busy",      bus.busy,         eb);
            chk("retire_cnt", bus.retire_cnt,  mcnt);
            if (bus.EX_RFWen)  chk("inv_ex",  {bus.EX_Valid,  bus.EX_WAddr  != 0}, 2'b11);
            if (bus.MEM_RFWen) chk("inv_mem", {bus.MEM_Valid, bus.MEM_WAddr != 0}, 2'b11);
            if (bus.WB_RFWen)  chk("inv_wb",  {bus.WB_Valid,  bus.WB_WAddr  != 0}, 2'b11);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ID_Valid = 0; bus.ID_WAddr = '0; bus.ID_RFWen = 0;
        bus.ID_WDataSc2 = 0; bus.stall = 0; bus.flush = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check_all_zero("release");
        @(negedge clk);

        // add r3 then lw r3
        step(1, 3, 1, 0, 0, 0);
        step(1, 3, 1, 1, 0, 0);
        chk("b2b_busy3", bus.busy[3], 1);
        chk("b2b_ex_sc2", bus.EX_WDataSc2, 1);
        idle(5);

        // stall bubble on lw r7, flush+stall on sub r9
        step(1, 7, 1, 1, 1, 0);
        step(1, 7, 1, 1, 0, 0);
        idle(4);
        step(1, 9, 1, 0, 1, 1);
        chk("flush_busy9", bus.busy[9], 0);
        idle(4);

        // write to r0, store with nonzero address field
        step(1, 0, 1, 0, 0, 0);
        step(1, 12, 0, 0, 0, 0);
        idle(4);

        // counter wrap: 17 back-to-back valid instructions
        for (int i = 0; i < 17; i++) step(1, 1 + (i % 30), 1, i[0], 0, 0);
        idle(4);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
        idle(4);

        // reset mid-stream with lw r5 in MEM
        step(1, 5, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("mid_mem_waddr", bus.MEM_WAddr, 5);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_all_zero("async_reset");
        bus.ID_Valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle(3);
        step(1, 6, 1, 0, 0, 0);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_tag_pipe.md
Name: wb_tag_pipe

Overview:
- Producer-side companion to the ID-stage JR hazard/forwarding logic.
- Carries each instruction's destination tag (write address, register-file write enable, memory-sourced-data flag) from ID through EX, MEM and WB.
- Publishes per-stage tags, a per-register pending-write scoreboard and a retired-instruction counter. Hazard and forwarding units consume these instead of decoding them locally.

Parameters:
RSIZE, 5, register address width; register file has 2**RSIZE entries
CNTW, 32, retired-instruction counter width

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
ID_Valid  input  1  ID holds a real instruction
ID_WAddr  input  RSIZE  destination register of ID instruction
ID_RFWen  input  1  ID instruction writes the register file
ID_WDataSc2  input  1  ID instruction's write data comes from data memory (load)
stall  input  1  hazard stall: ID held, bubble injected into EX
flush  input  1  squash ID instruction (taken branch/jump)
EX_Valid, MEM_Valid, WB_Valid  output  1 each  stage holds a real instruction
EX_WAddr, MEM_WAddr, WB_WAddr  output  RSIZE each  stage destination tag
EX_RFWen, MEM_RFWen, WB_RFWen  output  1 each  stage writes the register file
EX_WDataSc2, MEM_WDataSc2  output  1 each  stage write data is load data
busy  output  2**RSIZE  bit r=1: a write to register r is in flight in EX, MEM or WB
retire_cnt  output  CNTW  number of valid instructions that have left WB

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage Valid/RFWen/WDataSc2 bits = 0.
  - All WAddr = 0.
  - retire_cnt = 0.
  - busy = 0.
  - Release is synchronous to the next rising edge.
- Normalisation at ID capture:
  - Effective write en = ID_Valid & ID_RFWen & (ID_WAddr != 0).
  - If effective write en = 0, the stored WAddr = 0 and WDataSc2 = 0.
  - A valid instruction with no write (store, branch) still advances with Valid = 1.
- Each rising edge:
  - If stall | flush | !ID_Valid, EX is loaded with a bubble (Valid = 0, RFWen = 0, WAddr = 0, WDataSc2 = 0).
  - Otherwise EX is loaded with the normalised ID tag.
  - MEM <= EX and WB <= MEM unconditionally. The back end never stalls.
  - WB has no WDataSc2 output; by WB, load data is resolved.
- stall and flush in the same cycle: single bubble. flush needs no special handling downstream; already-issued stages are never squashed.
- Latency: ID tag appears on EX outputs 1 cycle after capture, on MEM after 2, on WB after 3, and is gone after 4.
- Outputs are registers except busy:
  - busy[r] = OR over S in {EX, MEM, WB} of (S_Valid & S_RFWen & S_WAddr == r).
  - busy[0] is always 0.
  - Multiple in-flight writers to the same r give busy[r] = 1 until the last one leaves WB.
- retire_cnt increments by 1 on each edge where WB_Valid = 1, meaning the WB instruction leaves. It wraps modulo 2**CNTW with no saturation or flag.
- Invariant checked by the bench: RFWen = 1 implies Valid = 1 and WAddr != 0.

Test Plan:
- Reset mid-stream: a load to r5 is in MEM; assert rst_n = 0 -> all outputs 0 immediately (before the next edge), busy = 0, retire_cnt = 0.
- Back-to-back writers: ID issues add r3, then lw r3 (WDataSc2 = 1), stall = 0 -> cycle 2: EX = r3/Sc2 = 1, MEM = r3/Sc2 = 0, busy[3] = 1. busy[3] stays 1 until the load leaves WB (cycle 5). retire_cnt = 2 after cycle 5.
- Stall bubble: ID holds lw r7, stall = 1 for 1 cycle then 0 -> EX Valid = 0 for 1 cycle, then EX = r7. MEM_WDataSc2 = 1 one cycle after that.
- Flush + stall together on sub r9 -> one bubble only. r9 never appears in any stage, busy[9] stays 0, retire_cnt unchanged for that slot.
- Register 0 and non-writers: ID_RFWen = 1 with ID_WAddr = 0, and a store with ID_RFWen = 0 and ID_WAddr = 12 -> both flow with Valid = 1, RFWen = 0, WAddr = 0. busy stays 0. retire_cnt +2.
- Counter wrap: CNTW = 4, stream 17 valid instructions -> retire_cnt goes 15 -> 0 -> 1, with no glitch on the other outputs.
